pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage SIMD AES pipeline.
- Generates per-stage enables and bubble/flush controls for the IF/ID, ID/EX and EX/MEM pipeline registers.
- Handles three events:
  - scalar load-use hazards;
  - multi-cycle vector (AES round) operations that hold EX;
  - data-memory wait states.

Parameters:
- VEC_LAT, 4, cycles a vector op occupies EX (legal 1..15).
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  pipeline clock; all state changes on posedge.
- rst_n  in  1  asynchronous active-low reset.
- id_rs1  in  5  ID-stage source register 1.
- id_rs2  in  5  ID-stage source register 2.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  5  EX-stage destination register.
- ex_MemToReg  in  1  EX instruction is a load.
- ex_RegWrite  in  1  EX instruction writes a scalar register.
- ex_vop  in  1  EX instruction is a multi-cycle vector op.
- ex_branch_taken  in  1  branch resolved taken in EX.
- mem_req  in  1  MEM stage accessing data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID register enable.
- id_ex_en  out  1  ID/EX register enable.
- ex_mem_en  out  1  EX/MEM register enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_flush  out  1  load NOP (all control bits 0) into ID/EX.
- ex_mem_bubble  out  1  load NOP into EX/MEM (RegWrite, VRegWrite, MemWrite, MemToReg = 0).
- vbusy  out  1  vector op in progress.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en = 0.

Behaviour:

States: RUN, VEXEC, MEMWAIT (registered). vcnt is a 4-bit registered down-counter.

Reset (async, rst_n = 0):
- state = RUN, vcnt = 0, stall_cnt = 0.
- Outputs are combinational from state and inputs. In RUN with all inputs 0 they give: all enables = 1, all flush/bubble = 0, vbusy = 0.
- Reset mid-operation aborts VEXEC/MEMWAIT immediately. No pending stall survives reset.

Evaluation priority within a cycle, highest first: MEMWAIT/memory stall > VEXEC > branch flush > load-use.

Memory stall:
- Condition: state = MEMWAIT, or mem_req = 1 with mem_ready = 0.
- All four enables = 0; flush/bubble = 0; nothing else is evaluated.
- Next state = MEMWAIT until the cycle in which mem_ready = 1.
- In that cycle enables return to 1 and the next state is the state the block held before entering MEMWAIT. This previous state is saved in a register.

RUN → VEXEC:
- Trigger: ex_vop = 1 and VEC_LAT > 1. Load vcnt = VEC_LAT - 2 and set vbusy = 1.
- In this cycle and every VEXEC cycle: pc_en = if_id_en = id_ex_en = 0; ex_mem_en = 1; ex_mem_bubble = 1.
- With VEC_LAT = 1, a vector op behaves like a scalar op: no stall and no vbusy.

VEXEC:
- vcnt decrements each cycle.
- When vcnt = 0: ex_mem_bubble = 0, all enables = 1, vbusy = 0, next state = RUN. The vector result enters EX/MEM in this cycle.
- Total EX occupancy is exactly VEC_LAT cycles; VEC_LAT - 1 bubbles are inserted into MEM.
- ex_branch_taken and load-use are ignored while in VEXEC.

Branch (RUN only, ex_branch_taken = 1):
- if_id_flush = 1 and id_ex_flush = 1; all enables = 1.
- Overrides a coincident load-use stall, because the younger instruction is discarded.

Load-use (RUN only):
- Condition: ex_MemToReg = 1, ex_RegWrite = 1, ex_rd ≠ 0, and (id_use_rs1 with id_rs1 = ex_rd, or id_use_rs2 with id_rs2 = ex_rd).
- Response: pc_en = if_id_en = 0, id_ex_flush = 1, id_ex_en = 1, ex_mem_en = 1.
- Exactly 1 bubble, because the stalled ID instruction re-evaluates against the new EX contents.
- Register 0 never triggers a stall.

stall_cnt:
- Increments by 1 on every posedge where pc_en = 0.
- Saturates at 2^CNT_W - 1; no wrap.

Simultaneous events:
- mem stall together with a new ex_vop: the vector op start is deferred until the memory stall ends, because EX is frozen.
- mem stall during VEXEC: vcnt holds (does not decrement) and VEXEC resumes afterwards.

Test Plan:
1. Reset release, all inputs 0 → pc_en = if_id_en = id_ex_en = ex_mem_en = 1; flushes and bubble = 0; stall_cnt = 0. Assert rst_n = 0 mid-VEXEC → same values immediately, vbusy = 0.
2. Load-use: ex_MemToReg = 1, ex_RegWrite = 1, ex_rd = 5, id_rs2 = 5, id_use_rs2 = 1 for one cycle → pc_en = 0, if_id_en = 0, id_ex_flush = 1 that cycle; stall_cnt = 1. Repeat with ex_rd = 0 → no stall.
3. Vector op, VEC_LAT = 4: ex_vop = 1 for one cycle → vbusy = 1 and ex_mem_bubble = 1 for 3 cycles, pc_en = 0 for 3 cycles; 4th cycle all enables = 1; stall_cnt = 3.
4. Branch coincident with load-use hazard → if_id_flush = id_ex_flush = 1, pc_en = 1, no stall.
5. Memory wait: mem_req = 1, mem_ready = 0 for 5 cycles, then 1 → all enables = 0 for exactly 5 cycles, released on the 6th. Repeat the same wait starting at VEXEC vcnt = 1 → VEXEC completes 5 cycles later than without the wait.
6. Saturation with CNT_W = 4: hold stall for 20 cycles → stall_cnt stops at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage SIMD AES pipeline: per-stage enables, bubble/flush
// controls, multi-cycle vector op hold in EX, data-memory wait states and a stall counter.
module pipe_hazard_ctrl #(
  parameter int unsigned VEC_LAT = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_MemToReg,
  input  logic             ex_RegWrite,
  input  logic             ex_vop,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic             vbusy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {StRun, StVexec, StMemwait} state_e;

  localparam bit         VecMulti = (VEC_LAT > 1);
  localparam logic [3:0] VecLoad  = VecMulti ? 4'(VEC_LAT - 2) : 4'd0;

  state_e           state_q, state_d, prev_q, prev_d, eff_state;
  logic [3:0]       vcnt_q, vcnt_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             mem_stall, load_use;

  assign mem_stall = ((state_q == StMemwait) || mem_req) && !mem_ready;

  assign load_use = ex_MemToReg && ex_RegWrite && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  // The release cycle of a memory wait is evaluated as the state that was interrupted.
  assign eff_state = (state_q == StMemwait) ? prev_q : state_q;

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    vbusy         = 1'b0;
    state_d       = state_q;
    prev_d        = prev_q;
    vcnt_d        = vcnt_q;

    if (mem_stall) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      if (state_q != StMemwait) begin
        prev_d  = state_q;
        state_d = StMemwait;
      end
    end else begin
      unique case (eff_state)
        StVexec: begin
          if (vcnt_q == 4'd0) begin
            state_d = StRun;
          end else begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_bubble = 1'b1;
            vbusy         = 1'b1;
            vcnt_d        = vcnt_q - 4'd1;
            state_d       = StVexec;
          end
        end
        default: begin
          state_d = StRun;
          if (ex_vop && VecMulti) begin
            pc_en         = 1'b0;
            if_id_en      = 1'b0;
            id_ex_en      = 1'b0;
            ex_mem_bubble = 1'b1;
            vbusy         = 1'b1;
            vcnt_d        = VecLoad;
            state_d       = StVexec;
          end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      prev_q      <= StRun;
      vcnt_q      <= 4'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      vcnt_q  <= vcnt_d;
      if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected control vectors queued at drive time, popped and
// compared against a default DUT and a CNT_W=4 DUT that share the same stimulus.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_MemToReg, ex_RegWrite, ex_vop, ex_branch_taken;
  logic        mem_req, mem_ready;
  logic        pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, ex_mem_bubble;
  logic        vbusy;
  logic [15:0] stall_cnt;
  logic        s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_if_id_flush, s_id_ex_flush;
  logic        s_ex_mem_bubble, s_vbusy;
  logic [3:0]  s_stall_cnt;
  logic [7:0]  ctrl, ctrl_sat;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, ex_mem_bubble, vbusy}
  localparam logic [7:0] IDLE = 8'b1111_0000;
  localparam logic [7:0] LU   = 8'b0011_0100;
  localparam logic [7:0] VS   = 8'b0001_0011;
  localparam logic [7:0] BR   = 8'b1111_1100;
  localparam logic [7:0] MS   = 8'b0000_0000;

  int n_cmp = 0;
  int n_err = 0;
  string      tag_q[$];
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_MemToReg(ex_MemToReg),
    .ex_RegWrite(ex_RegWrite), .ex_vop(ex_vop), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(pc_en), .if_id_en(if_id_en),
    .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_bubble(ex_mem_bubble), .vbusy(vbusy),
    .stall_cnt(stall_cnt)
  );

  pipe_hazard_ctrl #(.VEC_LAT(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .ex_MemToReg(ex_MemToReg),
    .ex_RegWrite(ex_RegWrite), .ex_vop(ex_vop), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_en(s_pc_en), .if_id_en(s_if_id_en),
    .id_ex_en(s_id_ex_en), .ex_mem_en(s_ex_mem_en), .if_id_flush(s_if_id_flush),
    .id_ex_flush(s_id_ex_flush), .ex_mem_bubble(s_ex_mem_bubble), .vbusy(s_vbusy),
    .stall_cnt(s_stall_cnt)
  );

  assign ctrl = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
                 ex_mem_bubble, vbusy};
  assign ctrl_sat = {s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_if_id_flush,
                     s_id_ex_flush, s_ex_mem_bubble, s_vbusy};

  task automatic clr();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_MemToReg = 1'b0; ex_RegWrite = 1'b0;
    ex_vop = 1'b0; ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // Called at a negedge with inputs already set; checks combinational outputs, then runs
  // through the next posedge to the following negedge.
  task automatic step(input string tag, input logic [7:0] exp);
    string      t;
    logic [7:0] e;
    tag_q.push_back(tag);
    exp_q.push_back(exp);
    #1;
    t = tag_q.pop_front();
    e = exp_q.pop_front();
    n_cmp++;
    assert (ctrl === e) else begin
      n_err++;
      $error("FAIL %s: ctrl observed %b expected %b", t, ctrl, e);
    end
    n_cmp++;
    assert (ctrl_sat === e) else begin
      n_err++;
      $error("FAIL %s_sat: ctrl observed %b expected %b", t, ctrl_sat, e);
    end
    @(negedge clk);
  endtask

  task automatic chk_cnt(input string tag, input int exp);
    logic [15:0] e16;
    logic [3:0]  e4;
    e16 = 16'(exp);
    e4  = (exp > 15) ? 4'd15 : 4'(exp);
    n_cmp++;
    assert (stall_cnt === e16) else begin
      n_err++;
      $error("FAIL %s: stall_cnt observed %0d expected %0d", tag, stall_cnt, e16);
    end
    n_cmp++;
    assert (s_stall_cnt === e4) else begin
      n_err++;
      $error("FAIL %s_sat: stall_cnt observed %0d expected %0d", tag, s_stall_cnt, e4);
    end
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    step("rst_hold", IDLE);
    chk_cnt("rst_cnt", 0);
    rst_n = 1'b1;
    step("idle", IDLE);
    chk_cnt("idle_cnt", 0);

    // Load-use on rs2, then x0 never stalls, then rs1, then no use flag.
    ex_MemToReg = 1'b1; ex_RegWrite = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    step("lu_rs2", LU);
    clr();
    step("post_lu", IDLE);
    chk_cnt("lu_cnt", 1);
    ex_MemToReg = 1'b1; ex_RegWrite = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b1;
    step("lu_x0", IDLE);
    ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1; id_rs2 = 5'd3;
    step("lu_rs1", LU);
    id_use_rs1 = 1'b0;
    step("lu_nouse", IDLE);
    clr();
    chk_cnt("lu2_cnt", 2);

    // Vector op, VEC_LAT = 4.
    ex_vop = 1'b1;
    step("v_start", VS);
    ex_vop = 1'b0;
    step("v_1", VS);
    step("v_2", VS);
    step("v_done", IDLE);
    chk_cnt("v_cnt", 5);

    // Branch wins over a coincident load-use.
    ex_MemToReg = 1'b1; ex_RegWrite = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
    ex_branch_taken = 1'b1;
    step("br_lu", BR);
    clr();
    chk_cnt("br_cnt", 5);

    // Branch ignored while in VEXEC.
    ex_vop = 1'b1;
    step("vb_start", VS);
    ex_vop = 1'b0; ex_branch_taken = 1'b1;
    step("vb_br", VS);
    ex_branch_taken = 1'b0;
    step("vb_2", VS);
    step("vb_done", IDLE);
    chk_cnt("vb_cnt", 8);

    // Memory wait of 5 cycles.
    mem_req = 1'b1;
    for (int i = 0; i < 5; i++) step("mw", MS);
    mem_ready = 1'b1;
    step("mw_rel", IDLE);
    clr();
    step("mw_after", IDLE);
    chk_cnt("mw_cnt", 13);

    // Memory wait while VEXEC sits at vcnt = 1: completion slips by 5 cycles.
    ex_vop = 1'b1;
    step("vm_start", VS);
    ex_vop = 1'b0;
    step("vm_1", VS);
    mem_req = 1'b1;
    for (int i = 0; i < 5; i++) step("vm_wait", MS);
    mem_ready = 1'b1;
    step("vm_resume", VS);
    clr();
    step("vm_done", IDLE);
    chk_cnt("vm_cnt", 21);

    // Vector op deferred until the memory stall releases.
    mem_req = 1'b1; ex_vop = 1'b1;
    step("dv_wait0", MS);
    step("dv_wait1", MS);
    mem_ready = 1'b1;
    step("dv_start", VS);
    clr();
    step("dv_1", VS);
    step("dv_2", VS);
    step("dv_done", IDLE);
    chk_cnt("dv_cnt", 26);

    // Reset mid-VEXEC takes effect immediately.
    ex_vop = 1'b1;
    step("rv_start", VS);
    ex_vop = 1'b0;
    step("rv_1", VS);
    rst_n = 1'b0;
    step("rv_reset", IDLE);
    chk_cnt("rv_cnt", 0);
    rst_n = 1'b1;
    step("rv_idle", IDLE);

    // Long stall: CNT_W=4 instance saturates at 15.
    mem_req = 1'b1;
    for (int i = 0; i < 20; i++) step("sat", MS);
    chk_cnt("sat_cnt", 20);
    mem_ready = 1'b1;
    step("sat_rel", IDLE);
    clr();
    step("sat_idle", IDLE);
    chk_cnt("sat_hold", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
